// File: rtl/bpm_pkg.sv
// Shared types, widths and default constants for the BPM window sequencer.
package bpm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2
  } state_e;

  localparam int COUNT_W = 8;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 8'd255;

  localparam int DEF_TICKS_PER_SEC = 50_000_000;
  localparam int DEF_WINDOW_SEC    = 10;
  localparam int DEF_ALARM_WINDOWS = 3;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int cntWidth(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  localparam int DEF_PRESC_W = cntWidth(DEF_TICKS_PER_SEC);
  localparam int DEF_SEC_W   = cntWidth(DEF_WINDOW_SEC);
  localparam int DEF_ABN_W   = cntWidth(DEF_ALARM_WINDOWS + 1);

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchroniser for the raw heartbeat input followed by a rising-edge detector.
module pulse_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level_sync,
  output logic rise_pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Shift the asynchronous input through the synchroniser and keep one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_sync = sync_q;
  assign rise_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/bpm_window_ctrl.sv
// Heartbeat window sequencer: counts pulse edges over a fixed window, publishes the
// frozen count to the BPM monitor and raises an alarm after repeated abnormal windows.
module bpm_window_ctrl
  import bpm_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int WINDOW_SEC    = DEF_WINDOW_SEC,
  parameter int ALARM_WINDOWS = DEF_ALARM_WINDOWS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               pulse_in,
  input  logic               bpm_state,
  output logic [COUNT_W-1:0] pulse_count,
  output logic               count_valid,
  output logic               alarm,
  output logic               busy
);

  localparam int PRESC_W = cntWidth(TICKS_PER_SEC);
  localparam int SEC_W   = cntWidth(WINDOW_SEC);
  localparam int ABN_W   = cntWidth(ALARM_WINDOWS + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(WINDOW_SEC - 1);
  localparam logic [ABN_W-1:0]   ABN_LAST   = ABN_W'(ALARM_WINDOWS);

  state_e state_q, state_d;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [COUNT_W-1:0] runCnt_q, runCnt_d;
  logic [COUNT_W-1:0] pulseCnt_q, pulseCnt_d;
  logic               countValid_q, countValid_d;
  logic [ABN_W-1:0]   abnRun_q, abnRun_d;
  logic               alarm_q, alarm_d;
  logic               busy_q;

  logic               levelSync;
  logic               risePulse;
  logic               windowEnd;
  logic [COUNT_W-1:0] runPlus;

  pulse_sync_edge u_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (pulse_in),
    .level_sync (levelSync),
    .rise_pulse (risePulse)
  );

  // Next-state logic: ARM holds off until the synchronised pulse is low so a pulse
  // already in progress at enable is never counted; dropping enable always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!enable)        state_d = ST_IDLE;
        else if (!levelSync) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Window timing and edge counting; an edge arriving in the window-end cycle belongs
  // to the ending window, and the next window starts immediately with no dead cycle.
  always_comb begin
    presc_d      = '0;
    sec_d        = '0;
    runCnt_d     = '0;
    pulseCnt_d   = pulseCnt_q;
    countValid_d = 1'b0;
    windowEnd    = (state_q == ST_COUNT) && enable &&
                   (presc_q == PRESC_LAST) && (sec_q == SEC_LAST);
    runPlus      = (risePulse && (runCnt_q != COUNT_MAX)) ? runCnt_q + COUNT_W'(1) : runCnt_q;
    if ((state_q == ST_COUNT) && enable) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        sec_d   = (sec_q == SEC_LAST) ? '0 : sec_q + SEC_W'(1);
      end else begin
        presc_d = presc_q + PRESC_W'(1);
        sec_d   = sec_q;
      end
      if (windowEnd) begin
        pulseCnt_d   = runPlus;
        countValid_d = 1'b1;
        runCnt_d     = '0;
      end else begin
        runCnt_d = runPlus;
      end
    end
  end

  // Abnormal-window run length, sampled only while the fresh count is being presented.
  always_comb begin
    abnRun_d = abnRun_q;
    if (state_d == ST_IDLE) begin
      abnRun_d = '0;
    end else if (countValid_q) begin
      if (!bpm_state)              abnRun_d = '0;
      else if (abnRun_q != ABN_LAST) abnRun_d = abnRun_q + ABN_W'(1);
    end
    alarm_d = (abnRun_d == ABN_LAST);
  end

  // State and datapath registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      sec_q        <= '0;
      runCnt_q     <= '0;
      pulseCnt_q   <= '0;
      countValid_q <= 1'b0;
      abnRun_q     <= '0;
      alarm_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      sec_q        <= sec_d;
      runCnt_q     <= runCnt_d;
      pulseCnt_q   <= pulseCnt_d;
      countValid_q <= countValid_d;
      abnRun_q     <= abnRun_d;
      alarm_q      <= alarm_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign pulse_count = pulseCnt_q;
  assign count_valid = countValid_q;
  assign alarm       = alarm_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_bpm_window_ctrl.sv
// Self-checking bench for bpm_window_ctrl: a short-window instance checked against a
// behavioural model plus scenario checks, and a long-window instance for saturation.
module tb_bpm_window_ctrl;

  localparam int TPS_A   = 4;
  localparam int WIN_SEC = 10;
  localparam int ALARM_N = 3;
  localparam int WIN_A   = TPS_A * WIN_SEC;
  localparam int TPS_B   = 400;
  localparam int WIN_B   = TPS_B * WIN_SEC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA = 1'b1, enA = 1'b0, pinA = 1'b0, bsA = 1'b0;
  logic [7:0] cntA;
  logic       validA, alarmA, busyA;
  logic       rstB = 1'b1, enB = 1'b0, pinB = 1'b0, bsB = 1'b0;
  logic [7:0] cntB;
  logic       validB, alarmB, busyB;

  int checks = 0;
  int errors = 0;

  bpm_window_ctrl #(.TICKS_PER_SEC(TPS_A), .WINDOW_SEC(WIN_SEC), .ALARM_WINDOWS(ALARM_N)) dutA (
    .clk(clk), .reset(rstA), .enable(enA), .pulse_in(pinA), .bpm_state(bsA),
    .pulse_count(cntA), .count_valid(validA), .alarm(alarmA), .busy(busyA)
  );

  bpm_window_ctrl #(.TICKS_PER_SEC(TPS_B), .WINDOW_SEC(WIN_SEC), .ALARM_WINDOWS(ALARM_N)) dutB (
    .clk(clk), .reset(rstB), .enable(enB), .pulse_in(pinB), .bpm_state(bsB),
    .pulse_count(cntB), .count_valid(validB), .alarm(alarmB), .busy(busyB)
  );

  // Reference model: pulse_in seen through a two-cycle synchroniser, a single window
  // position counting 0..WIN_A-1, and a run of consecutive abnormal windows.
  int         mHist [3] = '{0, 0, 0};
  int         mMode = 0;
  int         mPos = 0, mRun = 0, mAbn = 0;
  logic [7:0] mCount = 8'd0;
  logic       mValid = 1'b0, mAlarm = 1'b0, mBusy = 1'b0;

  always @(posedge clk) begin : refModel
    logic syncLvl, rise, prevValid;
    prevValid = mValid;
    syncLvl   = (mHist[1] != 0);
    rise      = (mHist[1] != 0) && (mHist[2] == 0);
    mHist[2]  = mHist[1];
    mHist[1]  = mHist[0];
    mHist[0]  = int'(pinA);
    if (rstA) begin
      mHist  = '{0, 0, 0};
      mMode  = 0; mPos = 0; mRun = 0; mAbn = 0;
      mCount = 8'd0; mValid = 1'b0; mAlarm = 1'b0; mBusy = 1'b0;
    end else begin
      mValid = 1'b0;
      if (mMode == 0) begin
        if (enA) mMode = 1;
      end else if (mMode == 1) begin
        if (!enA) mMode = 0;
        else if (!syncLvl) begin mMode = 2; mPos = 0; mRun = 0; end
      end else begin
        if (!enA) mMode = 0;
        else begin
          mRun = (mRun + int'(rise) > 255) ? 255 : mRun + int'(rise);
          if (mPos == WIN_A - 1) begin
            mCount = 8'(mRun); mValid = 1'b1; mRun = 0; mPos = 0;
          end else begin
            mPos = mPos + 1;
          end
        end
      end
      if (mMode == 0) mAbn = 0;
      else if (prevValid) mAbn = bsA ? ((mAbn + 1 > ALARM_N) ? ALARM_N : mAbn + 1) : 0;
      mAlarm = (mAbn == ALARM_N);
      mBusy  = (mMode != 0);
    end
  end

  task automatic applyStimulus(input logic rst, input logic en, input logic pin, input logic bs);
    rstA = rst; enA = en; pinA = pin; bsA = bs;
  endtask

  task automatic doReset();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (cntA !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", cntA); end
    checks++; if (validA !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", validA); end
    checks++; if (alarmA !== 1'b0) begin errors++; $display("[TB] FAIL reset_alarm: got %b expected 0", alarmA); end
    checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busyA); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic_window();
    logic pat [0:59];
    int off, strobes, strobeObs;
    logic [7:0] seen;
    for (int j = 0; j < 60; j++) pat[j] = 1'b0;
    off = $urandom_range(0, 3);
    for (int p = 0; p < 12; p++) begin pat[off + 3*p] = 1'b1; pat[off + 3*p + 1] = 1'b1; end
    strobes = 0; strobeObs = -1; seen = 8'd0;
    doReset();
    for (int j = 0; j < 60; j++) begin
      applyStimulus(1'b0, 1'b1, pat[j], 1'b0);
      @(negedge clk);
      checks++;
      if ({cntA, validA, alarmA, busyA} !== {mCount, mValid, mAlarm, mBusy}) begin
        errors++;
        $display("[TB] FAIL basic_model obs %0d: got cnt=%0d v=%b al=%b busy=%b expected cnt=%0d v=%b al=%b busy=%b",
                 j + 1, cntA, validA, alarmA, busyA, mCount, mValid, mAlarm, mBusy);
      end
      checks++; if (busyA !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy obs %0d: got %b expected 1", j + 1, busyA); end
      if (validA === 1'b1) begin strobes++; if (strobes == 1) begin strobeObs = j + 1; seen = cntA; end end
    end
    checks++; if (strobes != 1) begin errors++; $display("[TB] FAIL basic_strobes: got %0d expected 1", strobes); end
    checks++; if (strobeObs != 2 + WIN_A) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", strobeObs, 2 + WIN_A); end
    checks++; if (seen !== 8'd12) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 12", seen); end
  endtask

  task automatic test_boundary();
    logic pat [0:129];
    int n, strobes;
    int got [3];
    int expc [3];
    int expObs [3];
    for (int j = 0; j < 130; j++) pat[j] = 1'b0;
    n = $urandom_range(3, 8);
    for (int p = 0; p < n; p++) begin pat[2 + 3*p] = 1'b1; pat[3 + 3*p] = 1'b1; end
    pat[39] = 1'b1; pat[40] = 1'b1; pat[41] = 1'b1;
    pat[119] = 1'b1; pat[120] = 1'b1; pat[121] = 1'b1;
    expc = '{n + 1, 0, 1};
    expObs = '{WIN_A + 2, 2*WIN_A + 2, 3*WIN_A + 2};
    strobes = 0;
    doReset();
    for (int j = 0; j < 125; j++) begin
      applyStimulus(1'b0, 1'b1, pat[j], 1'b0);
      @(negedge clk);
      checks++;
      if ({cntA, validA, alarmA, busyA} !== {mCount, mValid, mAlarm, mBusy}) begin
        errors++;
        $display("[TB] FAIL boundary_model obs %0d: got cnt=%0d v=%b expected cnt=%0d v=%b", j + 1, cntA, validA, mCount, mValid);
      end
      if (validA === 1'b1) begin
        if (strobes < 3) begin
          got[strobes] = int'(cntA);
          checks++;
          if (j + 1 != expObs[strobes]) begin errors++; $display("[TB] FAIL boundary_timing %0d: got %0d expected %0d", strobes, j + 1, expObs[strobes]); end
        end
        strobes++;
      end
    end
    checks++; if (strobes != 3) begin errors++; $display("[TB] FAIL boundary_strobes: got %0d expected 3", strobes); end
    for (int k = 0; k < 3; k++) begin
      if (k < strobes) begin
        checks++;
        if (got[k] != expc[k]) begin errors++; $display("[TB] FAIL boundary_count %0d: got %0d expected %0d", k, got[k], expc[k]); end
      end
    end
  endtask

  task automatic test_arm_guard();
    logic pat [0:69];
    int k, strobes, strobeObs;
    logic [7:0] seen;
    for (int j = 0; j < 70; j++) pat[j] = (j < 10);
    k = $urandom_range(2, 6);
    for (int p = 0; p < k; p++) begin pat[14 + 4*p] = 1'b1; pat[15 + 4*p] = 1'b1; end
    strobes = 0; strobeObs = -1; seen = 8'd0;
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    for (int j = 0; j < 70; j++) begin
      applyStimulus(1'b0, 1'b1, pat[j], 1'b0);
      @(negedge clk);
      checks++;
      if ({cntA, validA, alarmA, busyA} !== {mCount, mValid, mAlarm, mBusy}) begin
        errors++;
        $display("[TB] FAIL arm_model obs %0d: got cnt=%0d v=%b busy=%b expected cnt=%0d v=%b busy=%b", j + 1, cntA, validA, busyA, mCount, mValid, mBusy);
      end
      if (validA === 1'b1) begin strobes++; if (strobes == 1) begin strobeObs = j + 1; seen = cntA; end end
    end
    checks++; if (strobes != 1) begin errors++; $display("[TB] FAIL arm_strobes: got %0d expected 1", strobes); end
    checks++; if (strobeObs != 12 + WIN_A + 1) begin errors++; $display("[TB] FAIL arm_latency: got %0d expected %0d", strobeObs, 12 + WIN_A + 1); end
    checks++; if (int'(seen) != k) begin errors++; $display("[TB] FAIL arm_count: got %0d expected %0d", seen, k); end
  endtask

  task automatic test_alarm();
    logic flags [0:5];
    int nStrobe, sIdx;
    logic pending, pendExp, bs, pin;
    flags = '{1'b1, 1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
    nStrobe = 0; pending = 1'b0; pendExp = 1'b0; pin = 1'b0;
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, flags[0]);
    for (int j = 0; j < 300 && nStrobe < 6; j++) begin
      @(negedge clk);
      checks++;
      if ({cntA, validA, alarmA, busyA} !== {mCount, mValid, mAlarm, mBusy}) begin
        errors++;
        $display("[TB] FAIL alarm_model obs %0d: got cnt=%0d v=%b al=%b expected cnt=%0d v=%b al=%b", j + 1, cntA, validA, alarmA, mCount, mValid, mAlarm);
      end
      if (pending) begin
        checks++;
        if (alarmA !== pendExp) begin errors++; $display("[TB] FAIL alarm_after_window %0d: got %b expected %b", nStrobe - 1, alarmA, pendExp); end
        pending = 1'b0;
      end
      if (validA === 1'b1) begin
        sIdx = nStrobe;
        bs = flags[sIdx];
        pendExp = (sIdx >= 2) && flags[sIdx] && flags[sIdx - 1] && flags[sIdx - 2];
        pending = 1'b1;
        nStrobe++;
      end else begin
        bs = flags[(nStrobe > 5) ? 5 : nStrobe];
      end
      pin = ($urandom_range(0, 2) == 0) ? ~pin : pin;
      applyStimulus(1'b0, 1'b1, pin, bs);
    end
    @(negedge clk);
    if (pending) begin
      checks++;
      if (alarmA !== pendExp) begin errors++; $display("[TB] FAIL alarm_last_window: got %b expected %b", alarmA, pendExp); end
    end
    checks++; if (nStrobe != 6) begin errors++; $display("[TB] FAIL alarm_windows: got %0d expected 6", nStrobe); end
  endtask

  task automatic test_abort_reset();
    logic pat [0:39];
    int expP, sawValid;
    logic [7:0] held;
    for (int j = 0; j < 40; j++) pat[j] = 1'($urandom_range(0, 1));
    expP = 0;
    for (int j = 0; j < 40; j++) if (pat[j] && (j == 0 || !pat[j - 1])) expP++;
    doReset();
    for (int j = 0; j < 42; j++) begin
      applyStimulus(1'b0, 1'b1, (j < 40) ? pat[j] : 1'b0, 1'b0);
      @(negedge clk);
    end
    held = cntA;
    checks++; if (int'(held) != expP) begin errors++; $display("[TB] FAIL abort_first_count: got %0d expected %0d", held, expP); end
    sawValid = 0;
    for (int j = 42; j < 120; j++) begin
      applyStimulus(1'b0, (j < 60), 1'($urandom_range(0, 1)), 1'b0);
      @(negedge clk);
      if (validA === 1'b1 && j > 42) sawValid++;
    end
    checks++; if (sawValid != 0) begin errors++; $display("[TB] FAIL abort_valid: got %0d strobes expected 0", sawValid); end
    checks++; if (cntA !== held) begin errors++; $display("[TB] FAIL abort_hold: got %0d expected %0d", cntA, held); end
    checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busyA); end
    checks++;
    if ({cntA, validA, alarmA, busyA} !== {mCount, mValid, mAlarm, mBusy}) begin
      errors++; $display("[TB] FAIL abort_model: got cnt=%0d expected cnt=%0d", cntA, mCount);
    end
    for (int j = 0; j < 41; j++) begin
      applyStimulus(1'b0, 1'b1, (j % 4 < 2), 1'b1);
      @(negedge clk);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if ({cntA, validA, alarmA, busyA} !== 11'd0) begin
      errors++; $display("[TB] FAIL midwindow_reset: got cnt=%0d v=%b al=%b busy=%b expected all 0", cntA, validA, alarmA, busyA);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    int strobes, expSat, badVal;
    expSat = (WIN_B / 4 > 255) ? 255 : WIN_B / 4;
    strobes = 0; badVal = 0;
    @(negedge clk);
    rstB = 1'b1; enB = 1'b0; pinB = 1'b0;
    repeat (2) @(negedge clk);
    rstB = 1'b0;
    for (int j = 0; j < 3*WIN_B + 5; j++) begin
      enB = 1'b1; pinB = ((j / 2) % 2 == 1);
      @(negedge clk);
      if (cntB !== 8'd0 && int'(cntB) != expSat) badVal++;
      if (validB === 1'b1) begin
        checks++;
        if (int'(cntB) != expSat || (j + 1 - 2) % WIN_B != 0) begin
          errors++; $display("[TB] FAIL saturation_window %0d: got %0d at obs %0d expected %0d", strobes, cntB, j + 1, expSat);
        end
        strobes++;
      end
    end
    checks++; if (strobes != 3) begin errors++; $display("[TB] FAIL saturation_strobes: got %0d expected 3", strobes); end
    checks++; if (badVal != 0) begin errors++; $display("[TB] FAIL saturation_wrap: got %0d bad cycles expected 0", badVal); end
    enB = 1'b0; rstB = 1'b1;
  endtask

  task automatic test_random();
    logic pin;
    pin = 1'b0;
    doReset();
    for (int j = 0; j < 2000; j++) begin
      pin = ($urandom_range(0, 2) == 0) ? ~pin : pin;
      applyStimulus(($urandom_range(0, 499) == 0), ($urandom_range(0, 79) != 0), pin, 1'($urandom_range(0, 1)));
      @(negedge clk);
      checks++;
      if ({cntA, validA, alarmA, busyA} !== {mCount, mValid, mAlarm, mBusy}) begin
        errors++;
        $display("[TB] FAIL random_model obs %0d: got cnt=%0d v=%b al=%b busy=%b expected cnt=%0d v=%b al=%b busy=%b",
                 j + 1, cntA, validA, alarmA, busyA, mCount, mValid, mAlarm, mBusy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_boundary();
    test_arm_guard();
    test_alarm();
    test_abort_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
